// File: rtl/disk_responder.sv
// Host-side UART sector responder: decodes 2-byte sector requests, writes or reads SECT_BYTES bytes of a byte store.
// Latency: store write 1 cycle after rx_valid; first reply byte TIMEOUT+3 cycles after DECIDE entry.
// Backpressure: reply bytes wait on tx_busy (guarded for 2 cycles after tx_start); rx bytes during a reply are dropped.
//
// Ports: clk/rst_n (sync, active-low); rx_data/rx_valid from the UART receiver;
// tx_data/tx_start/tx_busy to the UART transmitter; st_addr/st_we/st_wdata/st_re/st_rdata
// to the sector store (read data one cycle after st_re); busy/last_sect/op_done/op_is_read/op_err status.
module disk_responder #(
    parameter int SECT_BYTES = 512,
    parameter int TIMEOUT    = 20000,
    parameter int SECT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           rx_data,
    input  logic                                 rx_valid,
    output logic [7:0]                           tx_data,
    output logic                                 tx_start,
    input  logic                                 tx_busy,
    output logic [SECT_W+$clog2(SECT_BYTES)-1:0] st_addr,
    output logic                                 st_we,
    output logic [7:0]                           st_wdata,
    output logic                                 st_re,
    input  logic [7:0]                           st_rdata,
    output logic                                 busy,
    output logic [SECT_W-1:0]                    last_sect,
    output logic                                 op_done,
    output logic                                 op_is_read,
    output logic                                 op_err
);

    localparam int OFF_W = $clog2(SECT_BYTES);
    localparam int AW    = SECT_W + OFF_W;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SECT_BYTES - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SEC_HI, DECIDE, WR_DATA, RD_FETCH, RD_WAIT, RD_SEND, RD_DONE
    } state_t;

    state_t             state, state_n;
    logic [TW-1:0]      tmo, tmo_n;
    logic [OFF_W-1:0]   off, off_n;
    logic [15:0]        sect_r, sect_n;
    logic [7:0]         hold, hold_n;
    logic [1:0]         guard, guard_n;
    logic [7:0]         tx_data_n, st_wdata_n;
    logic               tx_start_n, st_we_n, st_re_n, op_done_n, op_err_n, op_is_read_n;
    logic [AW-1:0]      st_addr_n;
    logic [SECT_W-1:0]  last_sect_n;
    logic [SECT_W-1:0]  sect;
    logic               rx_take, tmo_run, tmo_hit, tx_ok;

    assign sect    = sect_r[SECT_W-1:0];
    assign busy    = (state != IDLE);
    // The "counter reaches TIMEOUT" event is the increment landing on TIMEOUT at this edge.
    assign tmo_hit = (tmo == TMO_LAST);
    // Guard keeps us from trusting tx_busy before the transmitter has had time to raise it.
    assign tx_ok   = !tx_busy && (guard == 2'd0);

    always_comb begin
        state_n      = state;
        off_n        = off;
        sect_n       = sect_r;
        hold_n       = hold;
        guard_n      = (guard != 2'd0) ? guard - 2'd1 : 2'd0;
        tx_data_n    = tx_data;
        tx_start_n   = 1'b0;
        st_addr_n    = st_addr;
        st_we_n      = 1'b0;
        st_wdata_n   = st_wdata;
        st_re_n      = 1'b0;
        last_sect_n  = last_sect;
        op_done_n    = 1'b0;
        op_err_n     = 1'b0;
        op_is_read_n = op_is_read;
        rx_take      = 1'b0;
        tmo_run      = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    sect_n[7:0] = rx_data;
                    rx_take     = 1'b1;
                    state_n     = SEC_HI;
                end
            end
            SEC_HI: begin
                tmo_run = 1'b1;
                if (rx_valid) begin
                    sect_n[15:8] = rx_data;
                    rx_take      = 1'b1;
                    state_n      = DECIDE;
                end else if (tmo_hit) begin
                    op_err_n     = 1'b1;
                    op_is_read_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            DECIDE: begin
                tmo_run = 1'b1;
                if (rx_valid) begin
                    // A byte before the silence window closes makes this a write.
                    rx_take    = 1'b1;
                    st_we_n    = 1'b1;
                    st_addr_n  = {sect, {OFF_W{1'b0}}};
                    st_wdata_n = rx_data;
                    off_n      = OFF_W'(1);
                    state_n    = WR_DATA;
                end else if (tmo_hit) begin
                    off_n     = '0;
                    st_re_n   = 1'b1;
                    st_addr_n = {sect, {OFF_W{1'b0}}};
                    state_n   = RD_FETCH;
                end
            end
            WR_DATA: begin
                tmo_run = 1'b1;
                if (rx_valid) begin
                    rx_take    = 1'b1;
                    st_we_n    = 1'b1;
                    st_addr_n  = {sect, off};
                    st_wdata_n = rx_data;
                    off_n      = off + OFF_W'(1);
                    if (off == OFF_LAST) begin
                        last_sect_n  = sect;
                        op_done_n    = 1'b1;
                        op_is_read_n = 1'b0;
                        state_n      = IDLE;
                    end
                end else if (tmo_hit) begin
                    op_err_n     = 1'b1;
                    op_is_read_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            // st_re was raised on the edge entering this state.
            RD_FETCH: state_n = RD_WAIT;
            RD_WAIT: begin
                hold_n  = st_rdata;
                state_n = RD_SEND;
            end
            RD_SEND: begin
                if (tx_ok) begin
                    tx_data_n  = hold;
                    tx_start_n = 1'b1;
                    guard_n    = 2'd2;
                    off_n      = off + OFF_W'(1);
                    if (off == OFF_LAST) begin
                        state_n = RD_DONE;
                    end else begin
                        st_re_n   = 1'b1;
                        st_addr_n = {sect, off + OFF_W'(1)};
                        state_n   = RD_FETCH;
                    end
                end
            end
            RD_DONE: begin
                if (tx_ok) begin
                    op_done_n    = 1'b1;
                    op_is_read_n = 1'b1;
                    last_sect_n  = sect;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (rx_take || (state_n != state)) begin
            tmo_n = '0;
        end else if (tmo_run) begin
            tmo_n = tmo + TW'(1);
        end else begin
            tmo_n = tmo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo        <= '0;
            off        <= '0;
            sect_r     <= '0;
            hold       <= '0;
            guard      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            st_addr    <= '0;
            st_we      <= 1'b0;
            st_wdata   <= '0;
            st_re      <= 1'b0;
            last_sect  <= '0;
            op_done    <= 1'b0;
            op_err     <= 1'b0;
            op_is_read <= 1'b0;
        end else begin
            state      <= state_n;
            tmo        <= tmo_n;
            off        <= off_n;
            sect_r     <= sect_n;
            hold       <= hold_n;
            guard      <= guard_n;
            tx_data    <= tx_data_n;
            tx_start   <= tx_start_n;
            st_addr    <= st_addr_n;
            st_we      <= st_we_n;
            st_wdata   <= st_wdata_n;
            st_re      <= st_re_n;
            last_sect  <= last_sect_n;
            op_done    <= op_done_n;
            op_err     <= op_err_n;
            op_is_read <= op_is_read_n;
        end
    end

endmodule

// File: tb/tb_disk_responder.sv
// Bench for disk_responder: random-gap write/read frames against a byte-store reference,
// a 40-cycle-per-byte transmitter model, timeouts, backpressure and mid-read reset.
module tb_disk_responder;
    localparam int T  = 64;
    localparam int SB = 512;
    localparam int SW = 16;
    localparam int AW = SW + 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic [AW-1:0] st_addr;
    logic          st_we;
    logic [7:0]    st_wdata;
    logic          st_re;
    logic [7:0]    st_rdata = 8'h00;
    logic          busy;
    logic [SW-1:0] last_sect;
    logic          op_done, op_is_read, op_err;

    disk_responder #(.SECT_BYTES(SB), .TIMEOUT(T), .SECT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .st_addr(st_addr), .st_we(st_we), .st_wdata(st_wdata), .st_re(st_re),
        .st_rdata(st_rdata), .busy(busy), .last_sect(last_sect), .op_done(op_done),
        .op_is_read(op_is_read), .op_err(op_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Byte store: mem holds what the DUT wrote, pre_mem holds bench preloads.
    logic [7:0] mem     [logic [AW-1:0]];
    logic [7:0] pre_mem [logic [AW-1:0]];
    logic [7:0] ref_mem [logic [AW-1:0]];
    always @(posedge clk) if (st_we) mem[st_addr] = st_wdata;
    always @(posedge clk)
        if (st_re) st_rdata <= mem.exists(st_addr) ? mem[st_addr]
                             : (pre_mem.exists(st_addr) ? pre_mem[st_addr] : 8'h00);

    // Monitor and transmitter model, sampled on the falling edge.
    logic [7:0]    tx_log[$];
    int            tx_cyc[$];
    logic [AW-1:0] wa_log[$];
    logic [7:0]    wd_log[$];
    int            wc_log[$];
    logic [AW-1:0] ex_a[$];
    logic [7:0]    ex_d[$];
    int            ex_c[$];
    int            n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;
    logic          done_rd = 1'b0, err_rd = 1'b0;
    logic [SW-1:0] done_sect = '0;
    int            excl_viol = 0, ovl_viol = 0, busy_cnt = 0;
    logic          hold = 1'b0;

    always @(negedge clk) begin
        if (st_we && st_re) excl_viol++;
        if (tx_start && st_we) excl_viol++;
        if (op_done && op_err) excl_viol++;
        if (st_we) begin
            wa_log.push_back(st_addr); wd_log.push_back(st_wdata); wc_log.push_back(cyc);
        end
        if (op_done) begin n_done++; done_cyc = cyc; done_rd = op_is_read; done_sect = last_sect; end
        if (op_err)  begin n_err++;  err_cyc = cyc;  err_rd = op_is_read; end
        if (tx_start) begin
            if (tx_busy) ovl_viol++;
            tx_log.push_back(tx_data); tx_cyc.push_back(cyc);
            busy_cnt = 40;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt > 0) || hold;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output int edge_c);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; edge_c = cyc + 1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int maxg);
        repeat ($urandom_range(0, maxg)) @(negedge clk);
    endtask

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete(); wa_log.delete(); wd_log.delete(); wc_log.delete();
        ex_a.delete(); ex_d.delete(); ex_c.delete();
    endtask

    task automatic write_frame(input logic [SW-1:0] s, input int nb, input bit rnd, output int last_e);
        int e;
        logic [7:0] d;
        send(s[7:0], e); gap(12);
        send(s[15:8], e); gap(12);
        for (int i = 0; i < nb; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            send(d, e);
            ref_mem[{s, 9'(i)}] = d;
            ex_a.push_back({s, 9'(i)}); ex_d.push_back(d); ex_c.push_back(e);
            if (i < nb - 1) gap(12);
        end
        last_e = e;
    endtask

    task automatic read_req(input logic [SW-1:0] s, output int k);
        int e;
        send(s[7:0], e); gap(12);
        send(s[15:8], k);
    endtask

    task automatic preload(input logic [SW-1:0] s, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < SB; i++) begin
            d = rnd ? 8'($urandom) : ~8'(i);
            pre_mem[{s, 9'(i)}] = d;
            ref_mem[{s, 9'(i)}] = d;
        end
    endtask

    task automatic wait_evt(input int budget, input int d0, input int e0, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_done != d0 || n_err != e0) begin seen = 1'b1; break; end
            @(posedge clk);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wa_log.size(), ex_a.size());
        for (int i = 0; i < ex_a.size() && i < wa_log.size(); i++) begin
            chk({tag, "_addr"}, wa_log[i], ex_a[i]);
            chk({tag, "_data"}, wd_log[i], ex_d[i]);
            chk({tag, "_cyc"},  wc_log[i], ex_c[i]);
        end
    endtask

    task automatic check_reply(input string tag, input logic [SW-1:0] s, input int n);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            chk({tag, "_byte"}, tx_log[i], ref_mem[{s, 9'(i)}]);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog got=%0d exp=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int le, k, d0, e0, n0, n1, e;
        bit seen;
        logic [SW-1:0] s;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {tx_start, st_we, st_re, op_done, op_err}, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_st_addr", st_addr, 0);
        chk("rst_st_wdata", st_wdata, 0);
        chk("rst_last_sect", last_sect, 0);
        chk("rst_is_read", op_is_read, 0);
        rst_n = 1'b1;

        // Full write frame to sector 3, data = offset
        clear_logs(); d0 = n_done; e0 = n_err;
        write_frame(16'h0003, SB, 1'b0, le);
        wait_evt(50, d0, e0, seen);
        chk("wr_done_seen", seen, 1);
        chk("wr_done_cnt", n_done - d0, 1);
        chk("wr_done_cyc", done_cyc, le);
        chk("wr_is_read", done_rd, 0);
        chk("wr_last_sect", done_sect, 16'h0003);
        check_writes("wr");
        @(negedge clk);
        chk("wr_busy_after", busy, 0);

        // Read sector 0x1234 with junk rx bytes injected during the reply
        preload(16'h1234, 1'b0);
        clear_logs(); d0 = n_done; e0 = n_err;
        read_req(16'h1234, k);
        for (int i = 0; i < T + 20 && tx_log.size() == 0; i++) @(posedge clk);
        chk("rd_first_seen", tx_log.size() > 0, 1);
        chk("rd_latency", (tx_cyc.size() > 0) ? tx_cyc[0] : -1, k + T + 3);
        repeat (20) begin
            repeat ($urandom_range(100, 600)) @(negedge clk);
            send(8'($urandom), e);
        end
        wait_evt(30000, d0, e0, seen);
        chk("rd_done_seen", seen, 1);
        chk("rd_err_cnt", n_err - e0, 0);
        chk("rd_is_read", done_rd, 1);
        chk("rd_last_sect", done_sect, 16'h1234);
        chk("rd_nbytes", tx_log.size(), SB);
        chk("rd_no_store_wr", wa_log.size(), 0);
        check_reply("rd", 16'h1234, SB);

        // Stalled write: 100 bytes then silence
        clear_logs(); d0 = n_done; e0 = n_err;
        write_frame(16'h0001, 100, 1'b1, le);
        wait_evt(T + 20, d0, e0, seen);
        chk("stall_err_seen", seen, 1);
        chk("stall_err_cyc", err_cyc, le + T);
        chk("stall_is_read", err_rd, 0);
        chk("stall_done_cnt", n_done - d0, 0);
        check_writes("stall");
        chk("stall_off100_untouched", mem.exists({16'h0001, 9'd100}), 0);
        @(negedge clk);
        chk("stall_busy", busy, 0);

        // Timeout waiting for the sector high byte
        d0 = n_done; e0 = n_err;
        send(8'($urandom), e);
        wait_evt(T + 20, d0, e0, seen);
        chk("sechi_err_seen", seen, 1);
        chk("sechi_err_cyc", err_cyc, e + T);
        chk("sechi_is_read", err_rd, 0);

        // Read with transmitter backpressure, then reset at byte 200
        s = 16'(16'h8000 | $urandom_range(0, 16'h7fff));
        preload(s, 1'b1);
        clear_logs(); d0 = n_done; e0 = n_err;
        read_req(s, k);
        for (int i = 0; i < 5000 && tx_log.size() < 50; i++) @(posedge clk);
        chk("bp_reach50", tx_log.size() >= 50, 1);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        n0 = tx_log.size();
        repeat (500) @(negedge clk);
        n1 = tx_log.size();
        chk("bp_hold_quiet", n1 - n0, 0);
        hold = 1'b0;
        repeat (30) @(negedge clk);
        chk("bp_release_one", tx_log.size() - n1, 1);
        for (int i = 0; i < 10000 && tx_log.size() < 200; i++) @(posedge clk);
        chk("rst_reach200", tx_log.size() >= 200, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2 * T) @(negedge clk);
        chk("midrst_no_err", n_err - e0, 0);
        chk("midrst_no_done", n_done - d0, 0);
        check_reply("bp", s, 200);

        // Write after reset completes normally
        s = 16'(16'h4000 | $urandom_range(0, 16'h3fff));
        clear_logs(); d0 = n_done; e0 = n_err;
        write_frame(s, SB, 1'b1, le);
        wait_evt(50, d0, e0, seen);
        chk("pw_done_seen", seen, 1);
        chk("pw_done_cyc", done_cyc, le);
        chk("pw_is_read", done_rd, 0);
        chk("pw_last_sect", done_sect, s);
        check_writes("pw");

        chk("exclusive_strobes", excl_viol, 0);
        chk("tx_start_while_busy", ovl_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/disk_responder.md
Name: disk_responder

Overview:
- Host-side end of the UART sector protocol spoken by the Disk block. Decodes sector requests from the byte stream and serves them from a byte-addressed backing store.
- Write request: 2 sector bytes followed by 512 data bytes. The block stores the data bytes.
- Read request: 2 sector bytes, then silence. The block replies with 512 bytes.
- Sits between an async_receiver/async_transmitter pair and a block-RAM or SD-cache sector store.

Parameters:
- SECT_BYTES, 512, bytes per sector transfer (power of two).
- TIMEOUT, 20000, idle clk cycles that separate "read" from "write" and abort stalled frames.
- SECT_W, 16, sector number width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.
- st_addr  out  SECT_W+9  byte address {sector, offset}.
- st_we  out  1  store write enable.
- st_wdata  out  8  store write data.
- st_re  out  1  store read enable; st_rdata valid the cycle after.
- st_rdata  in  8  store read data.
- busy  out  1  frame in progress (any state except IDLE).
- last_sect  out  SECT_W  sector of last completed operation.
- op_done  out  1  one-cycle pulse on successful completion.
- op_is_read  out  1  type of the last op_done/op_err (1 = read).
- op_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset, sampled on posedge clk with rst_n=0:
  - State goes to IDLE; all counters clear.
  - tx_start, st_we, st_re, op_done, op_err, busy go to 0.
  - tx_data, st_addr, st_wdata, last_sect, op_is_read go to 0.
  - Reset mid-frame drops the frame with no op_err. Store contents are untouched.
- Sector number is sent low byte first.
- Timeout counter: clears on every accepted rx_valid and on each state entry; increments every cycle in SEC_HI, DECIDE and WR_DATA.
- States:
  - IDLE: on rx_valid, latch sect[7:0] and go to SEC_HI.
  - SEC_HI: on rx_valid, latch sect[15:8] and go to DECIDE. If the counter reaches TIMEOUT, pulse op_err (op_is_read=0) and go to IDLE.
  - DECIDE:
    - rx_valid before TIMEOUT: this is a write. Write that byte at offset 0, set offset=1, go to WR_DATA.
    - Counter reaches TIMEOUT with no byte: this is a read. Go to RD_FETCH with offset=0.
  - WR_DATA:
    - Each rx_valid: st_we=1 for one cycle, st_addr={sect,offset}, st_wdata=rx_data, offset++.
    - After the write at offset SECT_BYTES-1: set last_sect=sect, pulse op_done, op_is_read=0, go to IDLE.
    - Timeout: pulse op_err and go to IDLE. Bytes already written stay written.
  - RD_FETCH: st_re=1 for one cycle with st_addr={sect,offset}. Go to RD_WAIT.
  - RD_WAIT: capture st_rdata into a holding register. Go to RD_SEND.
  - RD_SEND: when tx_busy=0 and the guard counter is 0:
    - tx_data=held byte, tx_start=1 for exactly one cycle, guard=2, offset++.
    - If offset was SECT_BYTES-1: go to RD_DONE. Otherwise go to RD_FETCH.
  - RD_DONE: wait for tx_busy=0 with guard 0 (last byte accepted), then pulse op_done, op_is_read=1, last_sect=sect, go to IDLE.
- Guard counter: decrements to 0 every cycle. It stops tx_busy from being sampled before the transmitter has raised it after a tx_start.
- rx_valid during RD_FETCH, RD_WAIT, RD_SEND or RD_DONE is discarded: no store write, no state change.
- Widths: offset counter is log2(SECT_BYTES) bits. Wrap-around never occurs because the frame ends at SECT_BYTES-1.
- Latency:
  - One rx byte produces its store write on the cycle after rx_valid.
  - Read: first tx_start at DECIDE entry + TIMEOUT + 3 cycles when tx_busy is low.
- Only one of st_we and st_re is ever high in a cycle. tx_start is never high while st_we is high.
- op_done and op_err are mutually exclusive and last one cycle each.

Test Plan:
- Write frame, TIMEOUT=64: rx bytes 0x03,0x00 then 512 bytes (i&0xFF), 10-cycle gaps -> 512 st_we pulses at st_addr 0x00600..0x007FF with matching data; op_done=1, op_is_read=0, last_sect=0x0003.
- Read frame: preload sector 0x1234 with (~i)&0xFF; send 0x34,0x12, then silence -> 64 cycles later 512 tx_start pulses, data 0xFF,0xFE,...; tx_busy model busy 40 cycles per byte; op_done=1, op_is_read=1, last_sect=0x1234.
- Stalled write: sector 0x0001 + 100 data bytes, then silence -> op_err pulse 64 cycles after the last byte; store offsets 0..99 written, offset 100 untouched; busy=0.
- Backpressure: during read, hold tx_busy=1 for 500 cycles -> no tx_start while high; exactly one tx_start after release; no byte skipped or duplicated.
- Reset mid-read at byte 200 -> next cycle tx_start=0, busy=0, no op_err. A following write frame completes normally.
- Rx bytes injected during read reply -> ignored: no st_we, reply of 512 bytes intact.
